// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: length limit,
// default patterns and the detection-mode encoding.
package seq_det_pkg;

  localparam int unsigned SEQ_LEN_MAX = 16;

  localparam logic [2:0] PAT_110 = 3'b110;
  localparam logic [2:0] PAT_101 = 3'b101;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear input that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_dual_param.sv
// Mealy detector for two programmable LEN-bit serial patterns with
// overlapping/non-overlapping modes and a saturating match counter.
//   state   | meaning
//   FILLING | fill_q < LEN-1, not enough history for a match
//   ARMED   | fill_q == LEN-1, a valid bit can complete a pattern
module seq_detect_dual_param
  import seq_det_pkg::*;
#(
  parameter int unsigned    LEN         = 3,
  parameter logic [LEN-1:0] PAT_A_RST   = LEN'(PAT_110),
  parameter logic [LEN-1:0] PAT_B_RST   = LEN'(PAT_101),
  parameter logic           OVERLAP_RST = 1'b1,
  parameter int unsigned    CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pat_a,
  input  logic [LEN-1:0]   cfg_pat_b,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic             hit_a,
  output logic             hit_b,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned       FILL_W   = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

  logic [LEN-1:0]    pat_a_q, pat_a_d;
  logic [LEN-1:0]    pat_b_q, pat_b_d;
  mode_e             mode_q, mode_d;
  logic [LEN-2:0]    hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              accept;
  logic              armed;
  logic [LEN-1:0]    window;

  // A 2-bit pattern keeps only one history bit, so there is nothing to shift.
  generate
    if (LEN == 2) begin : g_hist_one
      assign hist_shift = d;
    end else begin : g_hist_many
      assign hist_shift = {hist_q[LEN-3:0], d};
    end
  endgenerate

  assign accept = d_valid & ~cfg_load & ~rst;
  assign armed  = (fill_q == FILL_MAX);
  assign window = {hist_q, d};
  assign hit_a  = accept & armed & (window == pat_a_q);
  assign hit_b  = accept & armed & (window == pat_b_q);
  assign z      = hit_a | hit_b;

  always_comb begin
    pat_a_d = pat_a_q;
    pat_b_d = pat_b_q;
    mode_d  = mode_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (cfg_load) begin
      pat_a_d = cfg_pat_a;
      pat_b_d = cfg_pat_b;
      mode_d  = cfg_overlap ? OVERLAP : NON_OVERLAP;
      fill_d  = '0;
    end else if (d_valid) begin
      hist_d = hist_shift;
      // A non-overlapping hit consumes the whole window.
      if ((mode_q == NON_OVERLAP) && z) begin
        fill_d = '0;
      end else if (!armed) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_a_q <= PAT_A_RST;
      pat_b_q <= PAT_B_RST;
      mode_q  <= OVERLAP_RST ? OVERLAP : NON_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      pat_a_q <= pat_a_d;
      pat_b_q <= pat_b_d;
      mode_q  <= mode_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (z),
    .clr   (cnt_clr),
    .count (match_cnt)
  );

endmodule

// File: doc/seq_detect_dual_param.md
Name: seq_detect_dual_param

Overview:
- Parametrised Mealy serial-pattern detector: the next generation of the fixed 3-bit "110 or 101" detector.
- Watches a 1-bit stream for either of two runtime-programmable LEN-bit patterns (A, B).
- Selectable overlapping or non-overlapping detection, per-pattern hit flags and a saturating match counter.
- Sits on a serial input path; z feeds downstream framing/alarm logic.

Parameters:
- LEN, 3, pattern length in bits (2..16).
- PAT_A_RST, 3'b110, reset value of pattern A (width LEN).
- PAT_B_RST, 3'b101, reset value of pattern B (width LEN).
- OVERLAP_RST, 1, reset value of mode (1 = overlapping).
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d  in  1  serial data bit.
- d_valid  in  1  d is sampled this cycle.
- cfg_load  in  1  load cfg_pat_a/cfg_pat_b/cfg_overlap.
- cfg_pat_a  in  LEN  new pattern A; bit LEN-1 is the first bit received.
- cfg_pat_b  in  LEN  new pattern B, same ordering.
- cfg_overlap  in  1  new mode.
- cnt_clr  in  1  clear match counter.
- z  out  1  Mealy match: hit_a | hit_b.
- hit_a  out  1  pattern A completes on current d.
- hit_b  out  1  pattern B completes on current d.
- match_cnt  out  CNT_W  saturating count of cycles with z=1.

Behaviour:
- Reset (rst=1 at edge):
  - pat_a=PAT_A_RST, pat_b=PAT_B_RST, overlap=OVERLAP_RST.
  - hist=0, fill=0, match_cnt=0.
  - During a reset cycle, z/hit_a/hit_b are forced 0.
  - Reset mid-stream discards partial history; no match is possible until LEN-1 new valid bits have been seen.
- State:
  - hist[LEN-2:0]: the last LEN-1 valid bits, hist[0] = most recent.
  - fill: count 0..LEN-1 of valid history bits.
- Mealy outputs (combinational, same cycle as the completing bit, zero latency):
  - hit_a = d_valid & !cfg_load & !rst & (fill==LEN-1) & ({hist,d}==pat_a).
  - hit_b is the same expression with pat_b.
  - If pat_a==pat_b, both hits assert together; z is a single 1.
- On d_valid & !cfg_load:
  - hist <= {hist[LEN-3:0], d}.
  - Overlap mode, or no hit: fill <= min(fill+1, LEN-1).
  - Non-overlap mode and z=1: fill <= 0, so the next match needs LEN fresh bits.
- d_valid=0: all state holds and outputs are 0.
- cfg_load=1 (priority over d_valid):
  - Patterns and mode are registered and fill <= 0.
  - The d in that cycle is dropped and outputs are 0.
  - The new configuration is effective from the next cycle.
- match_cnt:
  - If z: +1, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority: with cnt_clr and z in the same cycle, the result is 0.
  - rst also clears it.
- Conceptual states for reviewers: FILLING (fill<LEN-1, no hits possible) -> ARMED (fill==LEN-1).
  - ARMED -> FILLING on a non-overlap hit, cfg_load or rst.
- Width rule: LEN==2 gives a 1-bit hist; the implementation must not reference hist[LEN-3:0] in that case (use a generate branch).

Decomposition:
- Shared package seq_det_pkg holds:
  - SEQ_LEN_MAX=16.
  - Default pattern constants PAT_110 and PAT_101.
  - Mode encoding enum (OVERLAP=1, NON_OVERLAP=0).
- One sub-module: sat_counter (parameter W; inputs inc, clr; output count).
  - Reusable by other detectors in the family.
- History/compare logic stays in the top module.

Test Plan:
1. Defaults, overlap mode:
   - Stimulus: after rst, drive d=1,0,1,1,0,0,1,1,0,1,0,1,0,1, all valid.
   - Required: z=1 on bits 3,5,9,10,12,14; hit_a only on 5,9; hit_b only on 3,10,12,14; match_cnt=6.
2. Same stream, cfg_load with cfg_overlap=0 and same patterns first:
   - Required: z only on bits 3,9,12; match_cnt=3.
3. Gaps and simultaneous events:
   - Insert d_valid=0 cycles between every bit of stream 1 → identical hits; z=0 in every gap cycle.
   - cnt_clr asserted on bit 5 (a hit) → match_cnt=0 after it, final count=4.
4. Reset and reprogramming:
   - rst asserted after bits 1,1 then d=0 → no hit; 110 is detected only after 3 post-reset bits.
   - Then cfg_load LEN=3 pat_a=111, pat_b=111 with 1,1,1,1 → hit_a=hit_b=1 on bits 3,4; match_cnt +2.
5. Saturation:
   - CNT_W=2, overlap, pattern 111, stream of 8 ones → z on bits 3..8 (6 hits); match_cnt reaches 3 and holds.
6. LEN=5, pat_a=5'b10110:
   - Stream 1,0,1,1,0,1,1,0 overlap → hit_a on bits 5 and 8.
   - Same stream, non-overlap → hit on bit 5 only.
